// File: rtl/tjmono2_cmd_pkg.sv
// ----------------------------------------------------------------------------
// tjmono2_cmd_pkg
// Shared types and constants for the TJ-Monopix2 command scheduler.
//   FRAME_W              : width of one command frame (16 bits)
//   SYNC_PATTERN_DEFAULT : sync/idle frame value (16'h817E)
//   frame_t              : kind of frame loaded at a boundary
//   state_t              : scheduler state (INIT sync burst / RUN)
//   pulse_hold()         : converts a pulse length into the hold count
// ----------------------------------------------------------------------------
package tjmono2_cmd_pkg;

   localparam int FRAME_W = 16;
   localparam logic [FRAME_W-1:0] SYNC_PATTERN_DEFAULT = 16'h817E;

   typedef enum logic [1:0] {
      FR_SYNC,
      FR_TRIG,
      FR_CFG
   } frame_t;

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_t;

   // Remaining high cycles after the first one; a zero length still
   // produces a single-cycle pulse.
   function automatic logic [7:0] pulse_hold(input logic [7:0] len);
      return (len == 8'd0) ? 8'd0 : len - 8'd1;
   endfunction

endpackage

// File: rtl/tjmono2_cmd_scheduler_if.sv
// ----------------------------------------------------------------------------
// tjmono2_cmd_scheduler_if
// Request side of the command scheduler: trigger frame handshake and
// configuration FIFO write port.
//   TRIG_FRAME/TRIG_VALID -> scheduler, TRIG_READY <- scheduler (accept strobe)
//   CFG_DATA/CFG_VALID    -> scheduler, CFG_READY  <- scheduler (FIFO not full)
// master: register/trigger logic; slave: scheduler.
// ----------------------------------------------------------------------------
interface tjmono2_cmd_scheduler_if;
   import tjmono2_cmd_pkg::*;

   logic [FRAME_W-1:0] TRIG_FRAME;
   logic               TRIG_VALID;
   logic               TRIG_READY;
   logic [FRAME_W-1:0] CFG_DATA;
   logic               CFG_VALID;
   logic               CFG_READY;

   modport master (
      output TRIG_FRAME, TRIG_VALID, CFG_DATA, CFG_VALID,
      input  TRIG_READY, CFG_READY
   );

   modport slave (
      input  TRIG_FRAME, TRIG_VALID, CFG_DATA, CFG_VALID,
      output TRIG_READY, CFG_READY
   );

endinterface

// File: rtl/tjmono2_cmd_fifo.sv
// ----------------------------------------------------------------------------
// tjmono2_cmd_fifo
// Synchronous first-word-fall-through FIFO for configuration frames.
//   clk, rst          : clock, asynchronous active-high reset
//   wr_en, wr_data    : write request (ignored while full)
//   rd_en             : pop the head word (ignored while empty)
//   rd_data           : current head word, valid while !empty
//   full, empty, level: occupancy status
// DEPTH must be a power of two.
// ----------------------------------------------------------------------------
module tjmono2_cmd_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LEVEL_FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      level_reg;
   logic             push;
   logic             pop;

   assign full  = (level_reg == LEVEL_FULL);
   assign empty = (level_reg == '0);
   assign level = level_reg;
   assign push  = wr_en && !full;
   assign pop   = rd_en && !empty;

   // Head must be visible in the same cycle as the frame-boundary decision,
   // so the read is combinational; a word written on an edge is only seen
   // after that edge.
   assign rd_data = mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_reg <= level_reg + (AW+1)'(1);
            2'b01:   level_reg <= level_reg - (AW+1)'(1);
            default: level_reg <= level_reg;
         endcase
      end
   end

endmodule

// File: rtl/tjmono2_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// tjmono2_cmd_scheduler
// Builds the TJ-Monopix2 LVDS_CMD serial stream out of 16-bit frames
// (trigger, buffered config, sync) and drives the external injection pulse.
//   LVDS_CMD_CLK   : command clock, one serial bit per cycle
//   RESETB_EXT     : asynchronous active-high reset
//   cmd            : trigger handshake + config FIFO write port (slave)
//   PULSE_REQ/LEN  : injection pulse request and length in cycles
//   LVDS_CMD       : registered serial command bit, MSB first
//   LVDS_PULSE_EXT : injection pulse
//   FIFO_LEVEL     : config FIFO occupancy
//   INIT_DONE      : initial sync burst finished
// Optional: define TJMONO2_CMD_STATS_EN to add TRIG_SENT_CNT/CFG_SENT_CNT,
// saturating counts of trigger and config frames loaded.
// ----------------------------------------------------------------------------
module tjmono2_cmd_scheduler
   import tjmono2_cmd_pkg::*;
#(
   parameter logic [FRAME_W-1:0] SYNC_PATTERN = SYNC_PATTERN_DEFAULT,
   parameter int SYNC_INTERVAL = 32,
   parameter int INIT_SYNCS    = 8,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                          LVDS_CMD_CLK,
   input  logic                          RESETB_EXT,
   tjmono2_cmd_scheduler_if.slave        cmd,
   input  logic                          PULSE_REQ,
   input  logic [7:0]                    PULSE_LEN,
   output logic                          LVDS_CMD,
   output logic                          LVDS_PULSE_EXT,
   output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
   output logic                          INIT_DONE
`ifdef TJMONO2_CMD_STATS_EN
   ,
   output logic [15:0]                   TRIG_SENT_CNT,
   output logic [15:0]                   CFG_SENT_CNT
`endif
);

   localparam int INIT_W = $clog2(INIT_SYNCS + 1);
   localparam int SYNC_W = $clog2(SYNC_INTERVAL + 1);
   localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_SYNCS);
   localparam logic [SYNC_W-1:0] SYNC_MAX  = SYNC_W'(SYNC_INTERVAL);

   state_t               state_reg, state_next;
   logic                 first_reg;
   logic [3:0]           bit_cnt_reg;
   logic [FRAME_W-1:0]   shift_reg;
   logic                 cmd_reg;
   logic [INIT_W-1:0]    init_cnt_reg, init_cnt_next;
   logic [SYNC_W-1:0]    nsync_cnt_reg, nsync_cnt_next;
   logic                 pulse_reg;
   logic [7:0]           pulse_cnt_reg;

   logic                 load;
   frame_t               sel_type;
   logic [FRAME_W-1:0]   sel_frame;
   logic                 trig_accept;
   logic                 fifo_pop;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [FRAME_W-1:0]   fifo_head;

   tjmono2_cmd_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (LVDS_CMD_CLK),
      .rst     (RESETB_EXT),
      .wr_en   (cmd.CFG_VALID),
      .wr_data (cmd.CFG_DATA),
      .rd_en   (fifo_pop),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (FIFO_LEVEL)
   );

   // Frame boundary: last bit of the current frame, or the very first edge
   // out of reset when no frame is in flight yet.
   assign load = first_reg || (bit_cnt_reg == 4'd0);

   assign cmd.CFG_READY  = !fifo_full;
   assign cmd.TRIG_READY = trig_accept;
   assign LVDS_CMD       = cmd_reg;
   assign LVDS_PULSE_EXT = pulse_reg;
   assign INIT_DONE      = (state_reg == ST_RUN);

   always_ff @(posedge LVDS_CMD_CLK or posedge RESETB_EXT) begin
      if (RESETB_EXT) begin
         state_reg     <= ST_INIT;
         init_cnt_reg  <= '0;
         nsync_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         init_cnt_reg  <= init_cnt_next;
         nsync_cnt_reg <= nsync_cnt_next;
      end
   end

   // Frame selection. INIT keeps sending syncs until INIT_SYNCS of them have
   // been loaded; the boundary where the last one ends already selects with
   // RUN priorities, so INIT_DONE rises exactly when that sync has finished.
   always_comb begin
      state_next     = state_reg;
      init_cnt_next  = init_cnt_reg;
      nsync_cnt_next = nsync_cnt_reg;
      sel_type       = FR_SYNC;
      sel_frame      = SYNC_PATTERN;
      fifo_pop       = 1'b0;
      trig_accept    = 1'b0;
      if (load) begin
         if (state_reg == ST_INIT && init_cnt_reg != INIT_LAST) begin
            init_cnt_next = init_cnt_reg + INIT_W'(1);
         end else begin
            state_next = ST_RUN;
            if (cmd.TRIG_VALID) begin
               // Triggers win even over an overdue sync.
               sel_type    = FR_TRIG;
               sel_frame   = cmd.TRIG_FRAME;
               trig_accept = 1'b1;
            end else if (nsync_cnt_reg != SYNC_MAX && !fifo_empty) begin
               sel_type  = FR_CFG;
               sel_frame = fifo_head;
               fifo_pop  = 1'b1;
            end
         end
         if (sel_type == FR_SYNC) begin
            nsync_cnt_next = '0;
         end else if (nsync_cnt_reg != SYNC_MAX) begin
            nsync_cnt_next = nsync_cnt_reg + SYNC_W'(1);
         end
      end
   end

   // Serializer: the loaded frame's MSB goes straight to the output register
   // on the load edge, the remaining 15 bits follow from the shift register.
   always_ff @(posedge LVDS_CMD_CLK or posedge RESETB_EXT) begin
      if (RESETB_EXT) begin
         first_reg   <= 1'b1;
         bit_cnt_reg <= 4'd15;
         shift_reg   <= '0;
         cmd_reg     <= 1'b0;
      end else begin
         first_reg <= 1'b0;
         if (load) begin
            cmd_reg     <= sel_frame[FRAME_W-1];
            shift_reg   <= {sel_frame[FRAME_W-2:0], 1'b0};
            bit_cnt_reg <= 4'd15;
         end else begin
            cmd_reg     <= shift_reg[FRAME_W-1];
            shift_reg   <= {shift_reg[FRAME_W-2:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg - 4'd1;
         end
      end
   end

   // Injection pulse, independent of framing. pulse_cnt_reg holds the number
   // of high cycles still to come after the current one.
   always_ff @(posedge LVDS_CMD_CLK or posedge RESETB_EXT) begin
      if (RESETB_EXT) begin
         pulse_reg     <= 1'b0;
         pulse_cnt_reg <= '0;
      end else if (!pulse_reg) begin
         if (PULSE_REQ) begin
            pulse_reg     <= 1'b1;
            pulse_cnt_reg <= pulse_hold(PULSE_LEN);
         end
      end else if (pulse_cnt_reg == 8'd0) begin
         pulse_reg <= 1'b0;
      end else begin
         pulse_cnt_reg <= pulse_cnt_reg - 8'd1;
      end
   end

`ifdef TJMONO2_CMD_STATS_EN
   logic [15:0] trig_sent_reg;
   logic [15:0] cfg_sent_reg;

   always_ff @(posedge LVDS_CMD_CLK or posedge RESETB_EXT) begin
      if (RESETB_EXT) begin
         trig_sent_reg <= '0;
         cfg_sent_reg  <= '0;
      end else if (load) begin
         if (sel_type == FR_TRIG && trig_sent_reg != 16'hFFFF) begin
            trig_sent_reg <= trig_sent_reg + 16'd1;
         end
         if (sel_type == FR_CFG && cfg_sent_reg != 16'hFFFF) begin
            cfg_sent_reg <= cfg_sent_reg + 16'd1;
         end
      end
   end

   assign TRIG_SENT_CNT = trig_sent_reg;
   assign CFG_SENT_CNT  = cfg_sent_reg;
`endif

endmodule

// File: tb/tb_tjmono2_cmd_scheduler.sv
// ----------------------------------------------------------------------------
// tb_tjmono2_cmd_scheduler
// Directed bench for the command scheduler. Stimulus pushes the expected
// frame sequence into exp_q; the monitor deserializes LVDS_CMD into 16-bit
// frames (aligned to the first edge after reset) and pops one entry per
// frame. With nothing queued, an idle sync frame is required.
// ----------------------------------------------------------------------------
module tb_tjmono2_cmd_scheduler;
   import tjmono2_cmd_pkg::*;

   localparam logic [15:0] SYNC = 16'h817E;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   tjmono2_cmd_scheduler_if bus ();
   logic       pulse_req;
   logic [7:0] pulse_len;
   logic       lvds_cmd;
   logic       lvds_pulse;
   logic [4:0] fifo_level;
   logic       init_done;
`ifdef TJMONO2_CMD_STATS_EN
   logic [15:0] trig_sent;
   logic [15:0] cfg_sent;
`endif

   tjmono2_cmd_scheduler dut (
      .LVDS_CMD_CLK   (clk),
      .RESETB_EXT     (rst),
      .cmd            (bus),
      .PULSE_REQ      (pulse_req),
      .PULSE_LEN      (pulse_len),
      .LVDS_CMD       (lvds_cmd),
      .LVDS_PULSE_EXT (lvds_pulse),
      .FIFO_LEVEL     (fifo_level),
      .INIT_DONE      (init_done)
`ifdef TJMONO2_CMD_STATS_EN
      ,
      .TRIG_SENT_CNT  (trig_sent),
      .CFG_SENT_CNT   (cfg_sent)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;
   int trig_pulses = 0;
   logic [15:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Edges since reset release; frame k is loaded on edge 1+16k.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic wait_cyc(input int e);
      do @(negedge clk); while (cyc < e);
   endtask

   task automatic cfg_write(input logic [15:0] d);
      bus.CFG_VALID = 1'b1;
      bus.CFG_DATA  = d;
      @(negedge clk);
      bus.CFG_VALID = 1'b0;
   endtask

   // Frame monitor / scoreboard.
   initial begin : monitor
      logic [15:0] fr;
      logic [15:0] want;
      int nb;
      int frame_no;
      nb = 0;
      fr = '0;
      frame_no = 0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            nb = 0;
         end else if (cyc >= 1) begin
            fr = {fr[14:0], lvds_cmd};
            nb++;
            if (nb == 16) begin
               nb = 0;
               want = (exp_q.size() > 0) ? exp_q.pop_front() : SYNC;
               check($sformatf("frame%0d", frame_no), {16'h0, fr}, {16'h0, want});
               $display("frame %0d: got 0x%04h expected 0x%04h", frame_no, fr, want);
               frame_no++;
            end
         end
      end
   end

   initial begin : trig_mon
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.TRIG_READY) trig_pulses++;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int idx;
      int hi;
      int first_hi;
      logic acc;
      logic got;
      logic full_seen;

      bus.TRIG_VALID = 1'b0;
      bus.TRIG_FRAME = '0;
      bus.CFG_VALID  = 1'b0;
      bus.CFG_DATA   = '0;
      pulse_req      = 1'b0;
      pulse_len      = 8'd0;

      // Reset values.
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_lvds_cmd",   {31'h0, lvds_cmd},        0);
      check("rst_pulse",      {31'h0, lvds_pulse},      0);
      check("rst_trig_ready", {31'h0, bus.TRIG_READY},  0);
      check("rst_cfg_ready",  {31'h0, bus.CFG_READY},   1);
      check("rst_fifo_level", {27'h0, fifo_level},      0);
      check("rst_init_done",  {31'h0, init_done},       0);
      rst = 1'b0;

      // 1: INIT syncs then idle syncs (frames 0..12).
      repeat (13) exp_q.push_back(SYNC);
      wait_cyc(128);
      check("init_done_before", {31'h0, init_done}, 0);
      wait_cyc(129);
      check("init_done_after", {31'h0, init_done}, 1);

      // 2: two config words back to back (frames 13, 14), then sync.
      wait_cyc(200);
      exp_q.push_back(16'h1234);
      exp_q.push_back(16'hABCD);
      exp_q.push_back(SYNC);
      exp_q.push_back(SYNC);
      cfg_write(16'h1234);
      cfg_write(16'hABCD);
      check("level_2", {27'h0, fifo_level}, 2);
      wait_cyc(209);
      check("level_1", {27'h0, fifo_level}, 1);
      wait_cyc(225);
      check("level_0", {27'h0, fifo_level}, 0);

      // 3: trigger beats three queued config words (frames 17..21).
      wait_cyc(257);
      exp_q.push_back(16'h2B55);
      exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222);
      exp_q.push_back(16'h3333);
      exp_q.push_back(SYNC);
      cfg_write(16'h1111);
      cfg_write(16'h2222);
      cfg_write(16'h3333);
      bus.TRIG_FRAME = 16'h2B55;
      bus.TRIG_VALID = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 64 && !got; i++) begin
         #1;
         if (bus.TRIG_READY) got = 1'b1;
         @(negedge clk);
      end
      bus.TRIG_VALID = 1'b0;
      check("trig_accepted", {31'h0, got}, 1);
      check("level_after_trig", {27'h0, fifo_level}, 3);
      wait_cyc(337);
      check("trig_ready_pulses", trig_pulses, 1);
      check("level_drained", {27'h0, fifo_level}, 0);

      // 4: 40 words, continuous writes; forced sync after 32 configs.
      wait_cyc(353);
      exp_q.push_back(SYNC);
      for (int i = 0; i < 32; i++) exp_q.push_back(16'(16'hC000 + i));
      exp_q.push_back(SYNC);
      for (int i = 32; i < 40; i++) exp_q.push_back(16'(16'hC000 + i));
      exp_q.push_back(SYNC);
      idx = 0;
      full_seen = 1'b0;
      for (int t = 0; t < 3000 && idx < 40; t++) begin
         bus.CFG_VALID = 1'b1;
         bus.CFG_DATA  = 16'(16'hC000 + idx);
         #1;
         acc = bus.CFG_READY;
         if (fifo_level == 5'd16 && !full_seen) begin
            full_seen = 1'b1;
            check("cfg_ready_at_full", {31'h0, bus.CFG_READY}, 0);
         end
         @(negedge clk);
         if (acc) idx++;
      end
      bus.CFG_VALID = 1'b0;
      check("words_written", idx, 40);
      check("full_reached", {31'h0, full_seen}, 1);
      wait_cyc(1025);
      check("level_after_40", {27'h0, fifo_level}, 0);
`ifdef TJMONO2_CMD_STATS_EN
      check("stats_trig", {16'h0, trig_sent}, 1);
      check("stats_cfg",  {16'h0, cfg_sent},  45);
`endif

      // 5: pulse length 5 with a retrigger attempt, then length 0.
      wait_cyc(1030);
      pulse_len = 8'd5;
      pulse_req = 1'b1;
      hi = 0;
      first_hi = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         pulse_req = (i == 1);
         if (i >= 1) pulse_len = 8'd9;
         #1;
         if (lvds_pulse) begin
            hi++;
            if (first_hi < 0) first_hi = i;
         end
      end
      check("pulse5_start", first_hi, 0);
      check("pulse5_width", hi, 5);
      pulse_len = 8'd0;
      pulse_req = 1'b1;
      hi = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         pulse_req = 1'b0;
         #1;
         if (lvds_pulse) hi++;
      end
      check("pulse0_width", hi, 1);

      // Trigger withdrawn mid-frame: never accepted, nothing sent.
      wait_cyc(1091);
      bus.TRIG_FRAME = 16'hDEAD;
      bus.TRIG_VALID = 1'b1;
      repeat (4) @(negedge clk);
      bus.TRIG_VALID = 1'b0;
      wait_cyc(1100);
      check("trig_withdrawn", trig_pulses, 1);

      // Word written on the boundary edge waits one frame (frames 69, 70).
      wait_cyc(1104);
      #2;
      exp_q.push_back(SYNC);
      exp_q.push_back(16'h4C4C);
      cfg_write(16'h4C4C);

      // 6: reset at bit 7 of config frame 71 (0x5A5A).
      wait_cyc(1122);
      cfg_write(16'h5A5A);
      cfg_write(16'h6B6B);
      wait_cyc(1145);
      check("level_before_rst", {27'h0, fifo_level}, 1);
      rst = 1'b1;
      #1;
      check("midrst_lvds_cmd",  {31'h0, lvds_cmd},       0);
      check("midrst_level",     {27'h0, fifo_level},     0);
      check("midrst_init_done", {31'h0, init_done},      0);
      check("midrst_cfg_ready", {31'h0, bus.CFG_READY},  1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (8) exp_q.push_back(SYNC);
      exp_q.push_back(16'h7777);
      exp_q.push_back(SYNC);
      wait_cyc(5);
      cfg_write(16'h7777);
      check("init_write_level", {27'h0, fifo_level}, 1);
      wait_cyc(128);
      check("init_no_pop", {27'h0, fifo_level}, 1);
      check("reinit_done_before", {31'h0, init_done}, 0);
      wait_cyc(129);
      check("reinit_done_after", {31'h0, init_done}, 1);
      check("first_run_pop", {27'h0, fifo_level}, 0);

      wait_cyc(170);
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
